// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: computes a - b - bin one DIGIT-bit slice per clock,
// LSB slice first, reporting diff, borrow-out and two's-complement overflow.
module seq_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = DIGIT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_s;
  logic [DIGIT-1:0] b_s;
  logic [DIGIT:0]   s_full;
  logic             last_slice;

  // Select the current operand slice; the top bit of s_full is the slice borrow.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (cnt == CW'(i)) begin
        a_s = a_r[i*DIGIT +: DIGIT];
        b_s = b_r[i*DIGIT +: DIGIT];
      end
    end
    s_full     = {1'b0, a_s} - {1'b0, b_s} - SW'(borrow);
    last_slice = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(N); i++) begin
            if (cnt == CW'(i)) diff[i*DIGIT +: DIGIT] <= s_full[DIGIT-1:0];
          end
          borrow <= s_full[DIGIT];
          if (last_slice) begin
            // Top slice MSB is the final diff sign bit.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= s_full[DIGIT];
            ovf   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (s_full[DIGIT-1] ^ a_r[WIDTH-1]);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// Scoreboard bench for seq_subtractor: three instances (DIGIT 4, 1, 16) share
// operands; a monitor pops expected results and due cycles on every done pulse.
module tb_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        st       [3];
  logic [15:0] a, b;
  logic        bin;
  logic        busy_o   [3];
  logic        done_o   [3];
  logic        bout_o   [3];
  logic        ovf_o    [3];
  logic [15:0] diff_o   [3];

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b), .bin(bin),
    .busy(busy_o[0]), .done(done_o[0]), .diff(diff_o[0]), .bout(bout_o[0]), .ovf(ovf_o[0]));
  seq_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(a), .b(b), .bin(bin),
    .busy(busy_o[1]), .done(done_o[1]), .diff(diff_o[1]), .bout(bout_o[1]), .ovf(ovf_o[1]));
  seq_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(st[2]), .a(a), .b(b), .bin(bin),
    .busy(busy_o[2]), .done(done_o[2]), .diff(diff_o[2]), .bout(bout_o[2]), .ovf(ovf_o[2]));

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          due;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } tv_t;

  exp_t q [3][$];
  int   cyc  = 0;
  int   vec  = 0;
  int   miss = 0;
  exp_t me;

  function automatic int nrun(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s dut%0d: got %0h, want %0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_o[i] === 1'b1) begin
        if (q[i].size() == 0) begin
          chk("done_without_request", i, {31'b0, done_o[i]}, 32'd0);
        end else begin
          me = q[i].pop_front();
          chk("diff", i, {16'b0, diff_o[i]}, {16'b0, me.d});
          chk("bout", i, {31'b0, bout_o[i]}, {31'b0, me.bo});
          chk("ovf", i, {31'b0, ovf_o[i]}, {31'b0, me.ov});
          chk("done_cycle", i, cyc, me.due);
          chk("busy_in_done", i, {31'b0, busy_o[i]}, 32'd0);
        end
      end
    end
  end

  // Called at a negedge: drive one start pulse to the masked instances.
  task automatic issue(input logic [2:0] mask, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic [15:0] ed, input logic ebo, input logic eov);
    exp_t e;
    a   = av;
    b   = bv;
    bin = bi;
    for (int i = 0; i < 3; i++) begin
      st[i] = mask[i];
      if (mask[i]) begin
        e.d   = ed;
        e.bo  = ebo;
        e.ov  = eov;
        e.due = cyc + 1 + nrun(i);
        q[i].push_back(e);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((q[0].size() + q[1].size() + q[2].size()) != 0)
      chk("timeout_pending", 0, q[0].size() + q[1].size() + q[2].size(), 32'd0);
    @(negedge clk);
  endtask

  tv_t tv [7];

  initial begin
    tv[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    tv[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tv[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tv[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0};
    tv[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tv[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    rst = 1'b1;
    a   = 16'h0;
    b   = 16'h0;
    bin = 1'b0;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, {31'b0, busy_o[i]}, 32'd0);
      chk("rst_done", i, {31'b0, done_o[i]}, 32'd0);
      chk("rst_diff", i, {16'b0, diff_o[i]}, 32'd0);
      chk("rst_bout", i, {31'b0, bout_o[i]}, 32'd0);
      chk("rst_ovf", i, {31'b0, ovf_o[i]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on all three digit widths concurrently.
    for (int v = 0; v < 7; v++) begin
      issue(3'b111, tv[v].a, tv[v].b, tv[v].bi, tv[v].d, tv[v].bo, tv[v].ov);
      for (int i = 0; i < 3; i++) chk("busy_after_start", i, {31'b0, busy_o[i]}, 32'd1);
      wait_idle();
      if (v == 0) begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("diff_hold", i, {16'b0, diff_o[i]}, 32'h1200);
      end
    end

    // start held with junk operands during RUN, then back-to-back in DONE.
    issue(3'b001, 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    a     = 16'hFFFF;
    b     = 16'h1111;
    bin   = 1'b1;
    st[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j < 3) chk("busy_while_start_held", 0, {31'b0, busy_o[0]}, 32'd1);
      @(negedge clk);
    end
    chk("first_done_seen", 0, {31'b0, done_o[0]}, 32'd1);
    issue(3'b001, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    chk("busy_back_to_back", 0, {31'b0, busy_o[0]}, 32'd1);
    wait_idle();

    // Reset in the second RUN cycle aborts the request without a done pulse.
    a     = 16'h1234;
    b     = 16'h0034;
    bin   = 1'b0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, {31'b0, busy_o[0]}, 32'd0);
    chk("abort_done", 0, {31'b0, done_o[0]}, 32'd0);
    chk("abort_diff", 0, {16'b0, diff_o[0]}, 32'd0);
    chk("abort_bout", 0, {31'b0, bout_o[0]}, 32'd0);
    chk("abort_ovf", 0, {31'b0, ovf_o[0]}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Recovery after the abort.
    issue(3'b111, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
